beta_alu_exec: RTL and testbench
================================

Name: beta_alu_exec

Overview:
Registered execute stage of the Beta ALU. It consumes the per-bit outputs of the 4:1 boolean-unit multiplexers and combines them with the adder, shifter and comparator results. It selects by ALUFN and registers the 32-bit result behind a valid/ready handshake. MUL is multi-cycle; the downstream writeback stage takes the result.

Parameters:
WIDTH, 32, datapath width; shift amount is B[$clog2(WIDTH)-1:0]
MUL_CYCLES, WIDTH, shift-add iterations for MUL

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand/op presented
in_ready  output  1  stage accepts this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_alufn  input  6  Beta ALUFN code
out_valid  output  1  result register holds data
out_ready  input  1  downstream consumes this cycle
out_result  output  WIDTH  registered result
out_illegal  output  1  ALUFN not supported; result forced 0

Behaviour:
- Reset values: out_valid=0, out_result=0, out_illegal=0, FSM=IDLE, MUL accumulator and counter=0. in_ready=0 during the reset cycle.
- Accept condition: in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready).
- ALUFN decode is fixed:
  - ADD 000000, SUB 000001, MUL 000010.
  - Boolean 01xxxx: bit i = ALUFN[{B[i],A[i]}], using one 4:1 mux per bit.
  - SHL 100000, SHR 100001, SRA 100011.
  - CMPEQ 110011, CMPLT 110101 (signed), CMPLE 110111 (signed); compare result is {31'b0, flag}.
  - Any other code is illegal.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag output. Shift by 0 returns A unchanged.
- Single-cycle ops: result and out_illegal are registered on the accept edge. out_valid rises the next cycle (latency 1). Throughput is 1 per cycle when out_ready is held high.
- FSM states:
  - IDLE: MUL accept -> MUL_BUSY, loading multiplicand A, multiplier B, accumulator 0, counter 0.
  - MUL_BUSY: each cycle, if multiplier LSB is set, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. When counter==MUL_CYCLES-1, write the low WIDTH bits to out_result, set out_valid, and go to IDLE.
- MUL latency: out_valid asserts MUL_CYCLES+1 cycles after the accept edge. in_ready stays 0 throughout MUL_BUSY.
- Backpressure: while out_valid & ~out_ready, out_result and out_illegal hold stable and in_ready=0.
- Simultaneous consume and accept: out_ready with a new accept replaces the result register in the same edge; out_valid stays 1.
- Reset mid-MUL: the operation is aborted, no result is produced, and state returns to IDLE.
- Inputs are ignored while in_ready=0; their values are don't-care.

Optional Feature:
BETA_MUL_EN
- Defined: MUL is implemented as described above.
- Undefined: the FSM and accumulator are not built, and MUL (000010) is treated as illegal. It completes in 1 cycle with out_illegal=1 and out_result=0. in_ready depends only on the output register.

Decomposition:
- Package beta_alu_pkg holds:
  - ALUFN localparams: ALU_ADD, ALU_SUB, ALU_MUL, ALU_SHL, ALU_SHR, ALU_SRA, ALU_CMPEQ, ALU_CMPLT, ALU_CMPLE, plus the BOOL class prefix 2'b01.
  - FSM state encoding: IDLE, MUL_BUSY.
- One sub-module, beta_bool_unit: WIDTH instances of the existing 4:1 mux, indexed by {B[i],A[i]} with ALUFN[3:0] as data. It is combinational.
- Adder, shifter and comparator stay inline.

Test Plan:
1. ADD A=0x00000005, B=0xFFFFFFFF; out_ready=1 -> next cycle out_valid=1, out_result=0x00000004, out_illegal=0.
2. Boolean XOR (010110), A=0xF0F0F0F0, B=0xFF00FF00 -> 0x0FF00FF0. AND (011000) on the same operands -> 0xF000F000. Issue back-to-back to verify 1/cycle throughput.
3. SRA A=0x80000000, B=4 -> 0xF8000000. SHR on the same operands -> 0x08000000. CMPLT A=0xFFFFFFFF, B=1 -> 0x00000001. CMPLE A=2, B=1 -> 0x00000000.
4. With BETA_MUL_EN, MUL A=0x00010001, B=0x00010001 -> out_result=0x00020001 exactly 33 cycles after accept; in_ready=0 for the whole interval. Without the macro, the same stimulus -> next cycle out_illegal=1, out_result=0.
5. Hold out_ready=0 for 5 cycles after an ADD result -> out_result stable, in_ready=0. Release out_ready with in_valid high -> the next op is accepted on that edge.
6. Assert reset at cycle 10 of a MUL -> next cycle out_valid=0, in_ready=1 one cycle after reset is deasserted, and no stale result appears.

Source files
------------

// File: rtl/beta_alu_pkg.sv
// Shared ALUFN codes and execute-stage FSM encoding for the Beta ALU.
package beta_alu_pkg;

   localparam logic [5:0] ALU_ADD   = 6'b000000;
   localparam logic [5:0] ALU_SUB   = 6'b000001;
   localparam logic [5:0] ALU_MUL   = 6'b000010;
   localparam logic [5:0] ALU_SHL   = 6'b100000;
   localparam logic [5:0] ALU_SHR   = 6'b100001;
   localparam logic [5:0] ALU_SRA   = 6'b100011;
   localparam logic [5:0] ALU_CMPEQ = 6'b110011;
   localparam logic [5:0] ALU_CMPLT = 6'b110101;
   localparam logic [5:0] ALU_CMPLE = 6'b110111;
   localparam logic [1:0] ALU_BOOL  = 2'b01;

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] MUL_BUSY = 1'b1;

   // Boolean class: the low four ALUFN bits are the truth table.
   function automatic logic is_bool(input logic [5:0] fn);
      return fn[5:4] == ALU_BOOL;
   endfunction

endpackage

// File: rtl/beta_bool_unit.sv
// Beta boolean unit: one 4:1 mux per bit, selected by {B[i],A[i]}, data = ALUFN[3:0].
module beta_bool_unit #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       fn_i,
   output logic [WIDTH-1:0] y_o
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_mux
         assign y_o[gi] = fn_i[{b_i[gi], a_i[gi]}];
      end
   endgenerate

endmodule

// File: rtl/beta_alu_exec.sv
// Registered Beta ALU execute stage with valid/ready handshake.
// Define BETA_MUL_EN to build the multi-cycle shift-add MUL; otherwise MUL is illegal.
module beta_alu_exec
   import beta_alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [5:0]       in_alufn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_illegal
);

   localparam int SHW = $clog2(WIDTH);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             illegal_q, illegal_d;
   logic [WIDTH-1:0] bool_y;
   logic [WIDTH-1:0] comb_result;
   logic             comb_illegal;
   logic             accept;
   logic             is_mul;
   logic             out_free;
   logic [SHW-1:0]   sh;

   assign sh       = in_b[SHW-1:0];
   assign out_free = ~out_valid_q | out_ready;
   assign accept   = in_valid & in_ready;

   beta_bool_unit #(.WIDTH(WIDTH)) u_bool (
      .a_i  (in_a),
      .b_i  (in_b),
      .fn_i (in_alufn[3:0]),
      .y_o  (bool_y)
   );

   always_comb begin
      comb_result  = '0;
      comb_illegal = 1'b0;
      if (is_bool(in_alufn)) begin
         comb_result = bool_y;
      end else begin
         case (in_alufn)
            ALU_ADD:   comb_result = in_a + in_b;
            ALU_SUB:   comb_result = in_a - in_b;
            ALU_SHL:   comb_result = in_a << sh;
            ALU_SHR:   comb_result = in_a >> sh;
            ALU_SRA:   comb_result = $signed(in_a) >>> sh;
            ALU_CMPEQ: comb_result = {{(WIDTH-1){1'b0}}, in_a == in_b};
            ALU_CMPLT: comb_result = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            ALU_CMPLE: comb_result = {{(WIDTH-1){1'b0}}, $signed(in_a) <= $signed(in_b)};
            default:   comb_illegal = 1'b1;
         endcase
      end
   end

`ifdef BETA_MUL_EN
   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_step;
   logic             mul_done;

   assign is_mul   = (in_alufn == ALU_MUL);
   assign in_ready = ~reset & (state_q == IDLE) & out_free;
   assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mul_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept & is_mul) begin
               state_d  = MUL_BUSY;
               mcand_d  = in_a;
               mplier_d = in_b;
               acc_d    = '0;
               cnt_d    = '0;
            end
         end
         MUL_BUSY: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
               mul_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end
`else
   assign is_mul   = 1'b0;
   assign in_ready = ~reset & out_free;
`endif

   // A consume empties the register unless a new result lands on the same edge.
   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      illegal_d   = illegal_q;
      if (out_ready) out_valid_d = 1'b0;
      if (accept & ~is_mul) begin
         out_valid_d = 1'b1;
         result_d    = comb_illegal ? '0 : comb_result;
         illegal_d   = comb_illegal;
      end
`ifdef BETA_MUL_EN
      if (mul_done) begin
         out_valid_d = 1'b1;
         result_d    = acc_step;
         illegal_d   = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         illegal_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_result  = result_q;
   assign out_illegal = illegal_q;

endmodule

// File: tb/tb_beta_alu_exec.sv
// Directed self-checking bench for beta_alu_exec; MUL expectations follow BETA_MUL_EN.
module tb_beta_alu_exec;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [5:0]  in_alufn;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_illegal;

   int total = 0;
   int bad   = 0;

   beta_alu_exec #(.WIDTH(32), .MUL_CYCLES(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_alufn    (in_alufn),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      in_alufn = fn;
      in_a     = a;
      in_b     = b;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_alufn = '0;
      tick(); tick();
      total++;
      if (out_valid !== 1'b0 || out_result !== 32'h0 || out_illegal !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: valid=%b result=%h illegal=%b ready=%b want 0/0/0/0",
                  out_valid, out_result, out_illegal, in_ready);
      end
      reset = 1'b0;
      tick();
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release: in_ready=%b want 1", in_ready);
      end
      $display("reset: ready=%b valid=%b", in_ready, out_valid);
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      drive(6'b000000, 32'h0000_0005, 32'hFFFF_FFFF);
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h0000_0004 || out_illegal !== 1'b0) begin
         bad++;
         $display("FAIL add: valid=%b result=%h illegal=%b want 1/00000004/0",
                  out_valid, out_result, out_illegal);
      end
      $display("add 5+ffffffff -> %h", out_result);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      drive(6'b010110, 32'hF0F0_F0F0, 32'hFF00_FF00);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h0FF0_0FF0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bool_xor: valid=%b result=%h ready=%b want 1/0ff00ff0/1",
                  out_valid, out_result, in_ready);
      end
      $display("xor -> %h", out_result);
      drive(6'b011000, 32'hF0F0_F0F0, 32'hFF00_FF00);
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'hF000_F000) begin
         bad++;
         $display("FAIL bool_and: valid=%b result=%h want 1/f000f000", out_valid, out_result);
      end
      $display("and -> %h", out_result);
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_shift_cmp();
      logic [5:0]  fn  [10];
      logic [31:0] va  [10];
      logic [31:0] vb  [10];
      logic [31:0] exp_r [10];
      logic        exp_i [10];
      fn[0] = 6'b100011; va[0] = 32'h8000_0000; vb[0] = 32'd4;  exp_r[0] = 32'hF800_0000; exp_i[0] = 0;
      fn[1] = 6'b100001; va[1] = 32'h8000_0000; vb[1] = 32'd4;  exp_r[1] = 32'h0800_0000; exp_i[1] = 0;
      fn[2] = 6'b110101; va[2] = 32'hFFFF_FFFF; vb[2] = 32'd1;  exp_r[2] = 32'h0000_0001; exp_i[2] = 0;
      fn[3] = 6'b110111; va[3] = 32'd2;         vb[3] = 32'd1;  exp_r[3] = 32'h0000_0000; exp_i[3] = 0;
      fn[4] = 6'b000001; va[4] = 32'd5;         vb[4] = 32'd7;  exp_r[4] = 32'hFFFF_FFFE; exp_i[4] = 0;
      fn[5] = 6'b100000; va[5] = 32'd1;         vb[5] = 32'd31; exp_r[5] = 32'h8000_0000; exp_i[5] = 0;
      fn[6] = 6'b100000; va[6] = 32'h1234_5678; vb[6] = 32'h20; exp_r[6] = 32'h1234_5678; exp_i[6] = 0;
      fn[7] = 6'b110011; va[7] = 32'd7;         vb[7] = 32'd7;  exp_r[7] = 32'h0000_0001; exp_i[7] = 0;
      fn[8] = 6'b110111; va[8] = 32'hFFFF_FFF0; vb[8] = 32'hFFFF_FFF0; exp_r[8] = 32'h0000_0001; exp_i[8] = 0;
      fn[9] = 6'b000011; va[9] = 32'd9;         vb[9] = 32'd9;  exp_r[9] = 32'h0000_0000; exp_i[9] = 1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(fn[i], va[i], vb[i]);
         tick();
         total++;
         if (out_valid !== 1'b1 || out_result !== exp_r[i] || out_illegal !== exp_i[i]) begin
            bad++;
            $display("FAIL vec%0d fn=%b: valid=%b result=%h illegal=%b want 1/%h/%b",
                     i, fn[i], out_valid, out_result, out_illegal, exp_r[i], exp_i[i]);
         end
         $display("vec%0d fn=%b a=%h b=%h -> %h ill=%b", i, fn[i], va[i], vb[i], out_result, out_illegal);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_mul();
      int k;
      out_ready = 1'b1;
      drive(6'b000010, 32'h0001_0001, 32'h0001_0001);
      tick();
      in_valid = 1'b0;
`ifdef BETA_MUL_EN
      k = 0;
      while (out_valid !== 1'b1 && k < 40) begin
         total++;
         if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mul_busy_ready: cycle %0d in_ready=%b want 0", k, in_ready);
         end
         tick();
         k++;
      end
      total++;
      if (k + 1 !== 33) begin
         bad++;
         $display("FAIL mul_latency: got %0d cycles want 33", k + 1);
      end
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h0002_0001 || out_illegal !== 1'b0) begin
         bad++;
         $display("FAIL mul_result: valid=%b result=%h illegal=%b want 1/00020001/0",
                  out_valid, out_result, out_illegal);
      end
`else
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h0 || out_illegal !== 1'b1) begin
         bad++;
         $display("FAIL mul_illegal: valid=%b result=%h illegal=%b want 1/00000000/1",
                  out_valid, out_result, out_illegal);
      end
`endif
      $display("mul 00010001*00010001 -> %h ill=%b", out_result, out_illegal);
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(6'b000000, 32'd3, 32'd4);
      tick();
      drive(6'b000000, 32'h10, 32'h20);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_result !== 32'd7 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold%0d: valid=%b result=%h ready=%b want 1/00000007/0",
                     i, out_valid, out_result, in_ready);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL release_ready: in_ready=%b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h30) begin
         bad++;
         $display("FAIL release_accept: valid=%b result=%h want 1/00000030", out_valid, out_result);
      end
      $display("backpressure held 7, then -> %h", out_result);
      tick();
   endtask

   task automatic test_reset_mid_mul();
      logic stale;
      out_ready = 1'b1;
      drive(6'b000010, 32'h0001_0001, 32'h0001_0001);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      reset = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL midmul_reset: valid=%b ready=%b want 0/0", out_valid, in_ready);
      end
      reset = 1'b0;
      tick();
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL midmul_ready: in_ready=%b want 1", in_ready);
      end
      stale = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid !== 1'b0) stale = 1'b1;
         tick();
      end
      total++;
      if (stale !== 1'b0) begin
         bad++;
         $display("FAIL midmul_stale: out_valid rose after reset");
      end
      $display("reset mid-mul: ready=%b stale=%b", in_ready, stale);
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_shift_cmp();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
